// File: rtl/vscale_csr_arbiter_pkg.sv
// Shared CSR command encodings, address width and arbiter state type
// used by the CSR port arbiter and its environment.
package vscale_csr_arbiter_pkg;

    localparam int CSR_ADDR_WIDTH = 12;
    localparam int CSR_CMD_WIDTH  = 3;

    localparam logic [CSR_CMD_WIDTH-1:0] CSR_IDLE  = 3'd0;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ  = 3'd4;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_SET   = 3'd6;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vscale_csr_arbiter.sv
// Shares the CSR file port between the pipeline (fixed priority, combinational)
// and a buffered host/debug requester with a starvation-bounded forced grant.
module vscale_csr_arbiter
    import vscale_csr_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      core_req,
    input  logic [CSR_ADDR_WIDTH-1:0] core_addr,
    input  logic [CSR_CMD_WIDTH-1:0]  core_cmd,
    input  logic [31:0]               core_wdata,
    output logic [31:0]               core_rdata,
    output logic                      core_illegal,
    output logic                      core_stall,
    input  logic                      host_req_valid,
    output logic                      host_req_ready,
    input  logic [CSR_ADDR_WIDTH-1:0] host_addr,
    input  logic [CSR_CMD_WIDTH-1:0]  host_cmd,
    input  logic [31:0]               host_wdata,
    output logic                      host_resp_valid,
    input  logic                      host_resp_ready,
    output logic [31:0]               host_resp_rdata,
    output logic                      host_resp_illegal,
    output logic                      csr_req,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    output logic [CSR_CMD_WIDTH-1:0]  csr_cmd,
    output logic [31:0]               csr_wdata,
    input  logic [31:0]               csr_rdata,
    input  logic                      csr_illegal
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CSR_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [CSR_CMD_WIDTH-1:0]  buf_cmd_q, buf_cmd_d;
    logic [31:0]               buf_wdata_q, buf_wdata_d;
    logic [31:0]               resp_rdata_q, resp_rdata_d;
    logic                      resp_illegal_q, resp_illegal_d;
    logic                      starved;
    logic                      host_grant;

    assign starved    = (cnt_q == LIMIT);
    assign host_grant = (state_q == ARB_WAIT) && (!core_req || starved);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ARB_IDLE;
            cnt_q          <= '0;
            buf_addr_q     <= '0;
            buf_cmd_q      <= '0;
            buf_wdata_q    <= '0;
            resp_rdata_q   <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            buf_addr_q     <= buf_addr_d;
            buf_cmd_q      <= buf_cmd_d;
            buf_wdata_q    <= buf_wdata_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        buf_addr_d     = buf_addr_q;
        buf_cmd_d      = buf_cmd_q;
        buf_wdata_d    = buf_wdata_q;
        resp_rdata_d   = resp_rdata_q;
        resp_illegal_d = resp_illegal_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (host_req_valid) begin
                    buf_addr_d  = host_addr;
                    buf_cmd_d   = host_cmd;
                    buf_wdata_d = host_wdata;
                    // Commands without bit 2 set never touch the CSR file.
                    if (host_cmd[2]) begin
                        state_d = ARB_WAIT;
                    end else begin
                        state_d        = ARB_RESP;
                        resp_rdata_d   = '0;
                        resp_illegal_d = 1'b1;
                    end
                end
            end
            ARB_WAIT: begin
                if (host_grant) begin
                    resp_rdata_d   = csr_rdata;
                    resp_illegal_d = csr_illegal;
                    cnt_d          = '0;
                    state_d        = ARB_RESP;
                end else begin
                    // No grant implies count is below the limit, so this saturates.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_RESP: begin
                if (host_resp_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        host_req_ready  = (state_q == ARB_IDLE);
        host_resp_valid = (state_q == ARB_RESP);
        core_stall      = host_grant && core_req;
        if (host_grant) begin
            csr_addr  = buf_addr_q;
            csr_cmd   = buf_cmd_q;
            csr_wdata = buf_wdata_q;
        end else begin
            csr_addr  = core_addr;
            csr_cmd   = core_cmd;
            csr_wdata = core_wdata;
        end
        csr_req      = (core_req || host_grant) && !csr_illegal;
        core_rdata   = core_stall ? '0 : csr_rdata;
        core_illegal = !core_stall && csr_illegal;
    end

    assign host_resp_rdata   = resp_rdata_q;
    assign host_resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_vscale_csr_arbiter.sv
// Randomized scoreboard bench for the CSR port arbiter with a behavioural
// CSR file stub and a transaction-level reference model.
`timescale 1ns/1ps
module tb_vscale_csr_arbiter;
    import vscale_csr_arbiter_pkg::*;

    localparam int unsigned LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        core_req = 1'b0;
    logic [11:0] core_addr = '0;
    logic [2:0]  core_cmd = CSR_READ;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_illegal;
    logic        core_stall;
    logic        host_req_valid = 1'b0;
    logic        host_req_ready;
    logic [11:0] host_addr = '0;
    logic [2:0]  host_cmd = CSR_READ;
    logic [31:0] host_wdata = '0;
    logic        host_resp_valid;
    logic        host_resp_ready = 1'b1;
    logic [31:0] host_resp_rdata;
    logic        host_resp_illegal;
    logic        csr_req;
    logic [11:0] csr_addr;
    logic [2:0]  csr_cmd;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    int pass_cnt = 0;
    int total_cnt = 0;
    int stall_cnt = 0;
    logic rand_mode = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
    } resp_t;
    resp_t exp_q[$];

    always #5 clk = ~clk;

    vscale_csr_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_req(core_req), .core_addr(core_addr), .core_cmd(core_cmd),
        .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_illegal(core_illegal), .core_stall(core_stall),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_addr(host_addr), .host_cmd(host_cmd), .host_wdata(host_wdata),
        .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
        .host_resp_rdata(host_resp_rdata), .host_resp_illegal(host_resp_illegal),
        .csr_req(csr_req), .csr_addr(csr_addr), .csr_cmd(csr_cmd),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal)
    );

    function automatic logic [31:0] init_val(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1888;
            12'h304: return 32'h0000_0008;
            12'hF11: return 32'h0000_0001;
            12'h341: return 32'h0000_0100;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] apply_cmd(input logic [2:0] c, input logic [31:0] old,
                                              input logic [31:0] w);
        case (c)
            CSR_WRITE: return w;
            CSR_SET:   return old | w;
            CSR_CLEAR: return old & ~w;
            default:   return old;
        endcase
    endfunction

    // Modifying commands to the top address quarter are read-only violations.
    function automatic logic is_illegal(input logic [11:0] a, input logic [2:0] c);
        return c[2] && (c != CSR_READ) && (a[11:10] == 2'b11);
    endfunction

    function automatic logic [11:0] addr_pick();
        logic [11:0] tbl [6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'hF11, 12'hC00};
        return tbl[$urandom_range(0, 5)];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // CSR file stub: combinational read, write applied at the edge.
    logic [31:0] env_mem [4096];
    logic        env_we;
    logic [11:0] env_waddr;
    logic [31:0] env_wval;
    assign csr_rdata   = env_mem[csr_addr];
    assign csr_illegal = is_illegal(csr_addr, csr_cmd);

    initial begin
        for (int i = 0; i < 4096; i++) env_mem[i] <= init_val(12'(i));
        forever begin
            @(negedge clk);
            env_we    = csr_req;
            env_waddr = csr_addr;
            env_wval  = apply_cmd(csr_cmd, csr_rdata, csr_wdata);
            @(posedge clk);
            if (env_we) env_mem[env_waddr] <= env_wval;
        end
    end

    // Reference model: host transactions and grant timing from the arbitration rules.
    logic [31:0] ref_mem [4096];
    logic        pend = 1'b0;
    int unsigned busy = 0;
    logic [11:0] pend_addr;
    logic [2:0]  pend_cmd;
    logic [31:0] pend_wdata;
    logic        pend_ill;

    initial begin
        logic grant;
        resp_t e;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend = 1'b0;
                busy = 0;
            end else begin
                if (core_stall) stall_cnt++;
                grant = pend && (!core_req || busy == LIMIT);
                chk("core_stall", 32'(core_stall), 32'(grant && core_req));
                if (grant) begin
                    chk("grant_csr_req", 32'(csr_req), 32'(!pend_ill));
                    chk("grant_csr_addr", 32'(csr_addr), 32'(pend_addr));
                    chk("grant_csr_cmd", 32'(csr_cmd), 32'(pend_cmd));
                    chk("grant_csr_wdata", csr_wdata, pend_wdata);
                    if (core_req) begin
                        chk("stall_core_rdata", core_rdata, 32'h0);
                        chk("stall_core_illegal", 32'(core_illegal), 32'h0);
                    end
                    if (!pend_ill) ref_mem[pend_addr] = apply_cmd(pend_cmd, ref_mem[pend_addr], pend_wdata);
                    pend = 1'b0;
                end else begin
                    chk("core_csr_req", 32'(csr_req), 32'(core_req));
                    if (core_req) begin
                        chk("core_csr_addr", 32'(csr_addr), 32'(core_addr));
                        chk("core_rdata_pass", core_rdata, csr_rdata);
                        chk("core_illegal_pass", 32'(core_illegal), 32'(csr_illegal));
                    end
                    if (pend && busy < LIMIT) busy++;
                end
                if (host_req_valid && host_req_ready) begin
                    if (!host_cmd[2]) begin
                        e.rdata = 32'h0;
                        e.ill   = 1'b1;
                    end else begin
                        e.rdata    = ref_mem[host_addr];
                        e.ill      = is_illegal(host_addr, host_cmd);
                        pend       = 1'b1;
                        busy       = 0;
                        pend_addr  = host_addr;
                        pend_cmd   = host_cmd;
                        pend_wdata = host_wdata;
                        pend_ill   = e.ill;
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
            end else if (host_resp_valid && host_resp_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL resp_unexpected: got response %h with empty queue", host_resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", host_resp_rdata, e.rdata);
                    chk("resp_illegal", 32'(host_resp_illegal), 32'(e.ill));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            core_req        = ($urandom_range(0, 99) < 85);
            core_addr       = addr_pick();
            core_cmd        = CSR_READ;
            core_wdata      = $urandom;
            host_resp_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic host_issue(input logic [11:0] a, input logic [2:0] c, input logic [31:0] w);
        int unsigned n = 0;
        host_req_valid = 1'b1;
        host_addr      = a;
        host_cmd       = c;
        host_wdata     = w;
        while (!host_req_ready) begin
            tick();
            n++;
            if (n > 200) begin
                total_cnt++;
                $display("FAIL req_ready_timeout: got ready=0 expected ready=1 within 200 cycles");
                break;
            end
        end
        tick();
        host_req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int unsigned lat);
        lat = 0;
        while (!(host_resp_valid && host_resp_ready)) begin
            tick();
            lat++;
            if (lat > 300) begin
                total_cnt++;
                $display("FAIL resp_timeout: got no response expected one within 300 cycles");
                break;
            end
        end
        tick();
    endtask

    task automatic do_host(input logic [11:0] a, input logic [2:0] c, input logic [31:0] w,
                           output int unsigned lat);
        host_issue(a, c, w);
        wait_resp(lat);
    endtask

    task automatic core_read_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        core_req  = 1'b1;
        core_addr = a;
        core_cmd  = CSR_READ;
        #1;
        chk(nm, core_rdata, exp);
        tick();
        core_req = 1'b0;
    endtask

    initial begin
        int unsigned lat;
        int          s0;
        logic [2:0]  c;
        int unsigned r;

        #1;
        chk("rst_req_ready", 32'(host_req_ready), 32'h1);
        chk("rst_resp_valid", 32'(host_resp_valid), 32'h0);
        chk("rst_resp_rdata", host_resp_rdata, 32'h0);
        chk("rst_resp_illegal", 32'(host_resp_illegal), 32'h0);
        chk("rst_core_stall", 32'(core_stall), 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Core idle: grant one cycle after acceptance.
        s0 = stall_cnt;
        do_host(12'h300, CSR_READ, 32'h0, lat);
        chk("t1_latency", 32'(lat), 32'd1);
        chk("t1_no_stall", 32'(stall_cnt - s0), 32'd0);

        // Core continuously busy: forced grant after the starvation limit.
        core_req  = 1'b1;
        core_addr = 12'h341;
        s0 = stall_cnt;
        do_host(12'h305, CSR_WRITE, 32'hCAFE_0001, lat);
        chk("t2_latency", 32'(lat), 32'(LIMIT + 1));
        chk("t2_stall_count", 32'(stall_cnt - s0), 32'd1);
        core_req = 1'b0;
        core_read_chk("t2_written", 12'h305, 32'hCAFE_0001);

        // Write to read-only region.
        do_host(12'hF11, CSR_WRITE, 32'hDEAD_BEEF, lat);
        core_read_chk("t3_unchanged", 12'hF11, 32'h0000_0001);

        // Set bits of mie.
        do_host(12'h304, CSR_SET, 32'h80, lat);
        core_read_chk("t4_mie_set", 12'h304, 32'h0000_0088);

        // Undefined command is answered without a CSR access.
        do_host(12'h300, CSR_IDLE, 32'hFFFF_FFFF, lat);
        chk("t4b_latency", 32'(lat), 32'd0);

        // Response backpressure.
        host_resp_ready = 1'b0;
        host_issue(12'h300, CSR_READ, 32'h0);
        lat = 0;
        while (!host_resp_valid && lat < 50) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t5_valid", 32'(host_resp_valid), 32'h1);
            chk("t5_rdata", host_resp_rdata, 32'h0000_1888);
            chk("t5_illegal", 32'(host_resp_illegal), 32'h0);
            chk("t5_req_ready", 32'(host_req_ready), 32'h0);
            tick();
        end
        host_resp_ready = 1'b1;
        tick();
        tick();

        // Asynchronous reset while a host write waits behind core traffic.
        core_req  = 1'b1;
        core_addr = 12'h341;
        host_issue(12'h300, CSR_WRITE, 32'h1234_5678);
        repeat (3) tick();
        #2;
        reset_n  = 1'b0;
        core_req = 1'b0;
        #1;
        chk("t6_resp_valid", 32'(host_resp_valid), 32'h0);
        chk("t6_resp_rdata", host_resp_rdata, 32'h0);
        chk("t6_core_stall", 32'(core_stall), 32'h0);
        chk("t6_csr_req", 32'(csr_req), 32'h0);
        chk("t6_req_ready", 32'(host_req_ready), 32'h1);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_post_valid", 32'(host_resp_valid), 32'h0);
            chk("t6_post_csr_req", 32'(csr_req), 32'h0);
            chk("t6_post_ready", 32'(host_req_ready), 32'h1);
        end
        core_read_chk("t6_dropped", 12'h300, 32'h0000_1888);

        // Randomized traffic.
        rand_mode = 1'b1;
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      c = (($urandom_range(0, 1) == 0) ? CSR_IDLE : 3'($urandom_range(1, 3)));
            else if (r <= 3) c = CSR_READ;
            else if (r <= 5) c = CSR_WRITE;
            else if (r <= 7) c = CSR_SET;
            else             c = CSR_CLEAR;
            do_host(addr_pick(), c, $urandom, lat);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_mode       = 1'b0;
        core_req        = 1'b0;
        host_resp_ready = 1'b1;
        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
